// File: rtl/rf_alu_sequencer.sv
// Fetch/decode/execute controller sitting in front of the RF+ALU datapath.
// Decoded datapath controls are registered when an instruction is accepted and cleared when EXEC retires.
module rf_alu_sequencer #(
    parameter int PC_WIDTH = 8,
    parameter int RESET_PC = 0
) (
    input  logic                clk,
    input  logic                clr,
    output logic                instr_req,
    output logic [PC_WIDTH-1:0] instr_addr,
    input  logic                instr_valid,
    input  logic [15:0]         instr_data,
    output logic [2:0]          Read_Addr_A,
    output logic [2:0]          Read_Addr_B,
    output logic [2:0]          Write_Addr,
    output logic                Write_En,
    output logic                Src_ALU_B,
    output logic                ADC,
    output logic                SUB,
    output logic                SBB,
    output logic [4:0]          imm5,
    output logic                Pre_C,
    input  logic                Z,
    input  logic                N,
    input  logic                C,
    input  logic                V,
    output logic [3:0]          cc_flags,
    output logic                halted,
    output logic                illegal
);

    // state  | meaning
    // FETCH  | request instruction at pc, wait for instr_valid
    // EXEC   | decoded controls live for one cycle; cc/pc updated at its closing edge
    // HALTED | HALT retired; idle until clr
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_ADC  = 5'b00010;
    localparam logic [4:0] OP_SUB  = 5'b00011;
    localparam logic [4:0] OP_SBB  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUBI = 5'b00110;
    localparam logic [4:0] OP_CMP  = 5'b00111;
    localparam logic [4:0] OP_BEQ  = 5'b01000;
    localparam logic [4:0] OP_BNE  = 5'b01001;
    localparam logic [4:0] OP_BCS  = 5'b01010;
    localparam logic [4:0] OP_JMP  = 5'b01011;
    localparam logic [4:0] OP_HALT = 5'b11111;

    // Wide enough that sign-extended off11 plus pc never loses the modulo result.
    localparam int EXT_W = PC_WIDTH + 11;

    typedef struct packed {
        logic [2:0] ra;
        logic [2:0] rb;
        logic [2:0] rd;
        logic [4:0] imm;
        logic       we;
        logic       src_b;
        logic       adc;
        logic       sub;
        logic       sbb;
    } ctrl_t;

    function automatic ctrl_t decode(input logic [15:0] w);
        ctrl_t c;
        c     = '0;
        c.ra  = w[7:5];
        c.rd  = w[10:8];
        c.imm = w[4:0];
        case (w[15:11])
            OP_ADD:  begin c.we = 1'b1; c.rb = w[4:2]; end
            OP_ADC:  begin c.we = 1'b1; c.rb = w[4:2]; c.adc = 1'b1; end
            OP_SUB:  begin c.we = 1'b1; c.rb = w[4:2]; c.sub = 1'b1; end
            OP_SBB:  begin c.we = 1'b1; c.rb = w[4:2]; c.sbb = 1'b1; end
            OP_ADDI: begin c.we = 1'b1; c.src_b = 1'b1; end
            OP_SUBI: begin c.we = 1'b1; c.src_b = 1'b1; c.sub = 1'b1; end
            OP_CMP:  begin c.rb = w[4:2]; c.sub = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

    state_t                state;
    logic [PC_WIDTH-1:0]   pc;
    logic [15:0]           ir;
    logic [3:0]            cc;
    ctrl_t                 ctrl;

    logic [4:0]            op;
    logic                  is_alu;
    logic                  is_legal;
    logic                  take;
    logic [EXT_W-1:0]      off_ext;
    logic [PC_WIDTH-1:0]   br_target;

    assign op       = ir[15:11];
    assign is_alu   = (op >= OP_ADD) && (op <= OP_CMP);
    assign is_legal = (op <= OP_JMP) || (op == OP_HALT);

    // Branch decision uses cc as registered before this EXEC.
    always_comb begin
        take    = 1'b0;
        off_ext = {{(EXT_W-8){ir[7]}}, ir[7:0]};
        case (op)
            OP_BEQ: take = cc[3];
            OP_BNE: take = ~cc[3];
            OP_BCS: take = cc[1];
            OP_JMP: begin
                take    = 1'b1;
                off_ext = {{(EXT_W-11){ir[10]}}, ir[10:0]};
            end
            default: ;
        endcase
        br_target = PC_WIDTH'({{11{1'b0}}, pc} + off_ext);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= FETCH;
            pc        <= PC_WIDTH'(RESET_PC);
            ir        <= '0;
            cc        <= '0;
            halted    <= 1'b0;
            illegal   <= 1'b0;
            ctrl      <= '0;
            instr_req <= 1'b1;
        end else begin
            case (state)
                FETCH: begin
                    if (instr_valid) begin
                        ir        <= instr_data;
                        pc        <= pc + PC_WIDTH'(1);
                        ctrl      <= decode(instr_data);
                        instr_req <= 1'b0;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    ctrl <= '0;
                    if (is_alu)
                        cc <= {Z, N, C, V};
                    if (!is_legal)
                        illegal <= 1'b1;
                    if (take)
                        pc <= br_target;
                    if (op == OP_HALT) begin
                        halted <= 1'b1;
                        state  <= HALTED;
                    end else begin
                        instr_req <= 1'b1;
                        state     <= FETCH;
                    end
                end
                HALTED: ;
                default: begin
                    ctrl      <= '0;
                    instr_req <= 1'b1;
                    state     <= FETCH;
                end
            endcase
        end
    end

    assign instr_addr  = pc;
    assign Read_Addr_A = ctrl.ra;
    assign Read_Addr_B = ctrl.rb;
    assign Write_Addr  = ctrl.rd;
    assign Write_En    = ctrl.we;
    assign Src_ALU_B   = ctrl.src_b;
    assign ADC         = ctrl.adc;
    assign SUB         = ctrl.sub;
    assign SBB         = ctrl.sbb;
    assign imm5        = ctrl.imm;
    assign cc_flags    = cc;
    assign Pre_C       = cc[1];

endmodule

// File: tb/tb_rf_alu_sequencer.sv
// Bench for rf_alu_sequencer: instruction-level model checked every cycle, plus directed literal pins.
module tb_rf_alu_sequencer;

    logic       clk = 1'b0;
    logic       clr;
    logic       instr_req;
    logic [7:0] instr_addr;
    logic       instr_valid;
    logic [15:0] instr_data;
    logic [2:0] Read_Addr_A, Read_Addr_B, Write_Addr;
    logic       Write_En, Src_ALU_B, ADC, SUB, SBB, Pre_C;
    logic [4:0] imm5;
    logic       Z, N, C, V;
    logic [3:0] cc_flags;
    logic       halted, illegal;

    always #5 clk = ~clk;

    rf_alu_sequencer #(.PC_WIDTH(8), .RESET_PC(0)) dut (
        .clk(clk), .clr(clr),
        .instr_req(instr_req), .instr_addr(instr_addr),
        .instr_valid(instr_valid), .instr_data(instr_data),
        .Read_Addr_A(Read_Addr_A), .Read_Addr_B(Read_Addr_B),
        .Write_Addr(Write_Addr), .Write_En(Write_En), .Src_ALU_B(Src_ALU_B),
        .ADC(ADC), .SUB(SUB), .SBB(SBB), .imm5(imm5), .Pre_C(Pre_C),
        .Z(Z), .N(N), .C(C), .V(V),
        .cc_flags(cc_flags), .halted(halted), .illegal(illegal)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // Architectural model: program counter, condition codes, sticky status.
    int         m_pc;
    logic [3:0] m_cc;
    bit         m_halt, m_ill;

    // Expected datapath controls for the current cycle.
    logic       e_req, e_we, e_srcb, e_adc, e_sub, e_sbb;
    logic [2:0] e_ra, e_rb, e_wa;
    logic [4:0] e_imm;

    typedef struct {
        logic [7:0] faddr;
        logic       we, srcb, adc, sub, sbb, prec;
        logic [2:0] wa;
        logic [4:0] imm;
    } snap_t;
    snap_t snap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("instr_req",   instr_req,   e_req);
            check("instr_addr",  instr_addr,  m_pc);
            check("Read_Addr_A", Read_Addr_A, e_ra);
            check("Read_Addr_B", Read_Addr_B, e_rb);
            check("Write_Addr",  Write_Addr,  e_wa);
            check("Write_En",    Write_En,    e_we);
            check("Src_ALU_B",   Src_ALU_B,   e_srcb);
            check("ADC",         ADC,         e_adc);
            check("SUB",         SUB,         e_sub);
            check("SBB",         SBB,         e_sbb);
            check("imm5",        imm5,        e_imm);
            check("Pre_C",       Pre_C,       m_cc[1]);
            check("cc_flags",    cc_flags,    m_cc);
            check("halted",      halted,      m_halt);
            check("illegal",     illegal,     m_ill);
        end
    end

    task automatic set_rest_exp();
        e_req = !m_halt;
        {e_ra, e_rb, e_wa, e_imm} = '0;
        {e_we, e_srcb, e_adc, e_sub, e_sbb} = '0;
    endtask

    task automatic set_exec_exp(input logic [15:0] w);
        int op;
        op     = int'(w[15:11]);
        e_req  = 1'b0;
        e_ra   = w[7:5];
        e_wa   = w[10:8];
        e_imm  = w[4:0];
        e_rb   = (op inside {1, 2, 3, 4, 7}) ? w[4:2] : 3'd0;
        e_we   = op inside {[1:6]};
        e_srcb = op inside {5, 6};
        e_adc  = (op == 2);
        e_sub  = op inside {3, 6, 7};
        e_sbb  = (op == 4);
    endtask

    task automatic model_exec(input logic [15:0] w, input logic [3:0] f);
        int op, off;
        bit take;
        op = int'(w[15:11]);
        if (op == 11)
            off = w[10] ? int'(w[10:0]) - 2048 : int'(w[10:0]);
        else
            off = w[7] ? int'(w[7:0]) - 256 : int'(w[7:0]);
        take = (op == 8 && m_cc[3]) || (op == 9 && !m_cc[3]) ||
               (op == 10 && m_cc[1]) || (op == 11);
        if (take) m_pc = ((m_pc + off) % 256 + 256) % 256;
        if (op >= 1 && op <= 7) m_cc = f;
        if (!(op <= 11 || op == 31)) m_ill = 1;
        if (op == 31) m_halt = 1;
    endtask

    // Fetch w after `stall` idle cycles, then run its EXEC with ALU flags f.
    task automatic run_instr(input logic [15:0] w, input int stall, input logic [3:0] f);
        for (int i = 0; i < stall; i++) begin
            instr_valid = 1'b0; instr_data = 16'hFFFF; {Z, N, C, V} = 4'hF;
            set_rest_exp();
            @(posedge clk); #1;
        end
        instr_valid = 1'b1; instr_data = w; {Z, N, C, V} = 4'hF;
        set_rest_exp();
        @(negedge clk);
        snap.faddr = instr_addr;
        @(posedge clk); #1;
        m_pc = (m_pc + 1) % 256;
        instr_valid = 1'b1; instr_data = 16'hFFFF; {Z, N, C, V} = f;
        set_exec_exp(w);
        @(negedge clk);
        snap.we = Write_En; snap.srcb = Src_ALU_B; snap.adc = ADC; snap.sub = SUB;
        snap.sbb = SBB; snap.prec = Pre_C; snap.wa = Write_Addr; snap.imm = imm5;
        @(posedge clk); #1;
        model_exec(w, f);
        instr_valid = 1'b0;
        set_rest_exp();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            instr_valid = 1'b1; instr_data = 16'h2905; {Z, N, C, V} = 4'hF;
            set_rest_exp();
            @(posedge clk); #1;
        end
    endtask

    // clr is applied while a valid instruction is offered, so it must win.
    task automatic do_reset();
        clr = 1'b1; instr_valid = 1'b1; instr_data = 16'h2905; {Z, N, C, V} = 4'hF;
        set_rest_exp();
        @(posedge clk); #1;
        clr = 1'b0; instr_valid = 1'b0;
        m_pc = 0; m_cc = 4'h0; m_halt = 0; m_ill = 0;
        set_rest_exp();
    endtask

    initial begin
        m_pc = 0; m_cc = 4'h0; m_halt = 0; m_ill = 0;
        set_rest_exp();
        clr = 1'b1; instr_valid = 1'b0; instr_data = 16'h0; {Z, N, C, V} = 4'h0;
        @(posedge clk); #1;
        do_reset();
        chk_en = 1;

        check("rst_req",     instr_req,  1);
        check("rst_addr",    instr_addr, 0);
        check("rst_cc",      cc_flags,   0);
        check("rst_halted",  halted,     0);
        check("rst_illegal", illegal,    0);

        // ADDI r1,r0,5
        run_instr(16'h2905, 0, 4'h0);
        check("addi_faddr", snap.faddr, 0);
        check("addi_we",    snap.we,    1);
        check("addi_srcb",  snap.srcb,  1);
        check("addi_wa",    snap.wa,    1);
        check("addi_imm",   snap.imm,   5);
        check("addi_strb",  {snap.adc, snap.sub, snap.sbb}, 0);
        check("addi_pc",    instr_addr, 1);

        run_instr(16'h0000, 3, 4'h0);
        check("stall_pc", instr_addr, 2);

        // CMP with Z=1,C=1 then ADC sees the carry
        run_instr(16'h3B28, 0, 4'b1010);
        check("cmp_we", snap.we,  0);
        check("cmp_cc", cc_flags, 4'b1010);
        run_instr(16'h1428, 0, 4'b0000);
        check("adc_prec", snap.prec, 1);
        check("adc_adc",  snap.adc,  1);
        check("adc_we",   snap.we,   1);

        run_instr(16'h1A70, 1, 4'b0101);
        run_instr(16'h25DC, 0, 4'b0011);
        run_instr(16'h315F, 0, 4'b1100);
        run_instr(16'h0FD7, 2, 4'b0110);

        // Branches taken
        do_reset();
        run_instr(16'h3B28, 0, 4'b1010);
        run_instr(16'h5002, 0, 4'h0);
        check("bcs_taken", instr_addr, 4);
        run_instr(16'h5805, 0, 4'h0);
        check("jmp_fwd", instr_addr, 10);
        run_instr(16'h40FE, 0, 4'h0);
        check("beq_taken", instr_addr, 9);

        // Branches with Z=0
        do_reset();
        run_instr(16'h3B28, 0, 4'b0000);
        run_instr(16'h5808, 0, 4'h0);
        run_instr(16'h40FE, 0, 4'h0);
        check("beq_not_taken", instr_addr, 11);
        run_instr(16'h48FE, 0, 4'h0);
        check("bne_taken", instr_addr, 10);

        // Wrap-around
        do_reset();
        run_instr(16'h58FE, 0, 4'h0);
        check("jmp_to_255", instr_addr, 255);
        run_instr(16'h0000, 0, 4'h0);
        check("pc_wrap", instr_addr, 0);
        run_instr(16'h5FFF, 0, 4'h0);
        check("jmp_minus1", instr_addr, 0);

        // Illegal, HALT, clr out of HALTED
        run_instr(16'hA800, 0, 4'h0);
        check("ill_we",   snap.we, 0);
        check("ill_flag", illegal, 1);
        run_instr(16'hF800, 0, 4'h0);
        check("halt_flag", halted,    1);
        check("halt_req",  instr_req, 0);
        idle(5);
        check("halt_hold", halted,     1);
        check("halt_pc",   instr_addr, 2);
        do_reset();
        check("clr_h_addr", instr_addr, 0);
        check("clr_h_halt", halted,     0);
        check("clr_h_ill",  illegal,    0);

        // clr mid-FETCH with an instruction on offer
        run_instr(16'h3B28, 0, 4'b1111);
        check("pre_clr_cc", cc_flags, 4'hF);
        do_reset();
        check("clr_f_cc",   cc_flags,   0);
        check("clr_f_addr", instr_addr, 0);
        check("clr_f_req",  instr_req,  1);
        run_instr(16'h2905, 1, 4'h0);
        check("post_clr_pc", instr_addr, 1);

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_alu_sequencer.md
Name: rf_alu_sequencer

Overview:
- Fetch/decode/execute controller directly upstream of the RF+ALU datapath.
- Fetches 16-bit instructions over a valid/req handshake and holds them in an instruction register (IR).
- Decodes IR into register addresses, ALU mode strobes, immediate and write enable.
- Holds the condition-code register (Z,N,C,V): samples ALU flags and feeds C back as Pre_C; resolves relative branches.
- The datapath's Write_Data is tied to its own Y at top level; this block only gates the write.

Parameters:
PC_WIDTH, 8, program counter / instruction address width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, all state on rising edge
clr  in  1  synchronous active-high reset
instr_req  out  1  fetch request, high only in FETCH
instr_addr  out  PC_WIDTH  fetch address (= pc)
instr_valid  in  1  instr_data valid this cycle
instr_data  in  16  fetched instruction
Read_Addr_A  out  3  RF port A address
Read_Addr_B  out  3  RF port B address
Write_Addr  out  3  RF write address
Write_En  out  1  RF write enable
Src_ALU_B  out  1  1 = imm5 to ALU B, 0 = OutB
ADC  out  1  add-with-carry mode
SUB  out  1  subtract mode
SBB  out  1  subtract-with-borrow mode
imm5  out  5  immediate field
Pre_C  out  1  carry/borrow in (= cc_c)
Z  in  1  ALU zero flag
N  in  1  ALU negative flag
C  in  1  ALU carry flag
V  in  1  ALU overflow flag
cc_flags  out  4  {Z,N,C,V} registered
halted  out  1  HALT executed
illegal  out  1  sticky: undefined opcode seen

Behaviour:
- Reset (clk edge with clr=1):
  - state=FETCH, pc=RESET_PC, IR=0, cc_flags=0, halted=0, illegal=0.
  - Any fetch in progress is abandoned; clr has priority over every other event.
- Encoding: op=IR[15:11], rd=IR[10:8], ra=IR[7:5], rb=IR[4:2], imm5=IR[4:0], off8=IR[7:0], off11=IR[10:0].
- Opcodes:
  - 00000 NOP.
  - 00001 ADD: all mode strobes 0.
  - 00010 ADC: ADC=1.
  - 00011 SUB: SUB=1.
  - 00100 SBB: SBB=1.
  - 00101 ADDI: Src_ALU_B=1.
  - 00110 SUBI: SUB=1, Src_ALU_B=1.
  - 00111 CMP: SUB=1, no write.
  - 01000 BEQ (Z), 01001 BNE (!Z), 01010 BCS (C): offset off8.
  - 01011 JMP: unconditional, offset off11.
  - 11111 HALT.
  - Any other opcode executes as NOP and sets illegal.
- Strobe rule: at most one of ADC/SUB/SBB is high in any cycle.
- FSM: FETCH -> EXEC -> FETCH; HALT -> HALTED. HALTED is left only by clr.
- FETCH:
  - instr_req=1, instr_addr=pc; all datapath controls 0 (Write_En=0).
  - On instr_valid=1: IR<=instr_data, pc<=pc+1 (mod 2^PC_WIDTH), go to EXEC.
  - On instr_valid=0: hold state.
- EXEC (one cycle):
  - instr_req=0.
  - Read_Addr_A=ra. Read_Addr_B=rb for register ops, else 0. Write_Addr=rd. imm5=IR[4:0].
  - Write_En=1 only for ADD/ADC/SUB/SBB/ADDI/SUBI.
  - At the closing edge, flags {Z,N,C,V} are captured into cc_flags for all ALU ops including CMP; otherwise cc_flags hold.
- Pre_C is cc_c combinationally at all times. It reflects flags from the previous ALU instruction, not the current one.
- Branch:
  - Taken: pc <= pc + sext(offset) truncated to PC_WIDTH. pc is already incremented, so the offset is relative to the next instruction.
  - Not taken: pc unchanged.
  - The branch decision uses cc_flags registered before this EXEC.
- HALT:
  - halted=1 from the edge ending that EXEC; pc frozen; instr_req=0; Write_En=0.
- Wrap-around: pc=2^PC_WIDTH-1 increments to 0. Branch arithmetic is modulo 2^PC_WIDTH.
- instr_valid outside FETCH is ignored.
- illegal stays set until clr.

Test Plan:
- Reset, then ADDI r1,r0,5 with instr_valid=1 in first FETCH cycle -> instr_addr=0 during fetch. In the next cycle: Write_En=1, Src_ALU_B=1, Write_Addr=1, imm5=5, all strobes 0. pc=1 after.
- instr_valid held 0 for 3 cycles then 1 -> instr_req stays 1 and pc/IR unchanged until accept. Exactly one EXEC follows.
- CMP where the ALU returns Z=1,C=1, then ADC -> during ADC EXEC: Pre_C=1, ADC=1, Write_En=1. CMP's EXEC has Write_En=0. cc_flags=4'b1010 after CMP.
- BEQ off8=8'hFE at pc=10 with Z=1 -> next instr_addr=9. Same instruction with Z=0 -> next instr_addr=11.
- pc=255 fetch -> next fetch address 0. JMP off11=11'h7FF at pc=0 -> next fetch address 0.
- Opcode 10101 -> illegal=1, Write_En=0. Then HALT -> halted=1, instr_req=0 indefinitely. clr mid-HALTED or mid-FETCH -> pc=RESET_PC, all flags 0 on the next edge.
